// File: rtl/bcd_event_counter.sv
// Multi-digit BCD up/down counter. Counts timebase ticks or synchronised sensor edges
// and drives a time-multiplexed seven-segment nibble/select pair.
module bcd_event_counter #(
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned DIV_COUNT   = 25_000_000,
    parameter int unsigned SCAN_DIV    = 50_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  evt_in,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  carry,
    output logic [3:0]            scan_digit,
    output logic [DIGITS-1:0]     scan_sel
);

    localparam int unsigned DIV_W  = $clog2(DIV_COUNT);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned ARM_W  = $clog2(SYNC_STAGES + 2);

    logic [DIV_W-1:0]       div_cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   evt_prev;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;
    logic                   evt_pulse;
    logic                   step;
    logic [4*DIGITS-1:0]    inc_val;
    logic [4*DIGITS-1:0]    dec_val;
    logic [4*DIGITS-1:0]    ld_val;
    logic                   all_nines;
    logic                   all_zeros;
    logic [SCAN_W-1:0]      scan_cnt;
    logic [IDX_W-1:0]       scan_idx;

    // Prescaler; tick is registered one cycle early so it lines up with div_cnt == DIV_COUNT-1
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_W'(DIV_COUNT - 1)) ? '0 : div_cnt + DIV_W'(1);
            tick    <= (div_cnt == DIV_W'(DIV_COUNT - 2));
        end
    end

    // Sensor synchroniser, edge detector and post-reset arming window
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            evt_prev <= 1'b0;
            arm_cnt  <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], evt_in};
            evt_prev <= sync_q[SYNC_STAGES-1];
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    assign armed     = (arm_cnt == ARM_W'(SYNC_STAGES + 1));
    assign evt_pulse = sync_q[SYNC_STAGES-1] & ~evt_prev & armed;
    assign step      = en & (mode ? evt_pulse : tick);

    // Per-nibble BCD increment/decrement chains and load clamping
    always_comb begin
        inc_val   = count;
        dec_val   = count;
        ld_val    = load_val;
        all_nines = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (all_nines) begin
                inc_val[4*i +: 4] = (count[4*i +: 4] == 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
            end
            if (all_zeros) begin
                dec_val[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? 4'd9 : count[4*i +: 4] - 4'd1;
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                ld_val[4*i +: 4] = 4'd9;
            end
            all_nines = all_nines & (count[4*i +: 4] == 4'd9);
            all_zeros = all_zeros & (count[4*i +: 4] == 4'd0);
        end
    end

    // Count register: clr > load > step > hold; carry marks a full wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            carry <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (load) begin
                count <= ld_val;
            end else if (step) begin
                count <= up_dn ? inc_val : dec_val;
                carry <= up_dn ? all_nines : all_zeros;
            end
        end
    end

    // Display scan: slot counter, digit index and one-hot select move together
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            scan_sel <= DIGITS'(1);
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (scan_idx == IDX_W'(DIGITS - 1)) begin
                scan_idx <= '0;
                scan_sel <= DIGITS'(1);
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
                scan_sel <= scan_sel << 1;
            end
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        scan_digit = count[3:0];
        for (int i = 1; i < int'(DIGITS); i++) begin
            if (scan_idx == IDX_W'(i)) begin
                scan_digit = count[4*i +: 4];
            end
        end
    end

endmodule
